additive_osc: RTL and testbench

Four-partial additive sine oscillator that produces one 16-bit unsigned sample per request for the PCM5102 I2S output stage. It time-multiplexes a single 256x16 sine lookup table across four harmonics with fixed weights and mixes them into one output word. It sits directly upstream of the DAC: the I2S block's frame clock, edge-detected into the `clk` domain, drives `sample_req`; `sample_out` feeds the DAC's left/right inputs.

---
 rtl/additive_osc.sv | 123 ++++++++++++
 tb/tb_additive_osc.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/additive_osc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : additive_osc
//  Description : Four-partial additive sine oscillator sharing one 256x16 LUT;
//                weights 4,3,2,1 on harmonics 1..4, one sample per request.
//  Revision    : 1.0 - initial release
// ============================================================================
module additive_osc #(
    parameter int PHASE_W = 24,
    parameter int ACC_W   = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_req,
    input  logic [PHASE_W-1:0] base_inc,
    output logic [7:0]         lut_addr,
    input  logic [15:0]        lut_data,
    output logic [15:0]        sample_out,
    output logic               sample_valid,
    output logic               busy,
    output logic               overrun
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ACC  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         r_k;
    logic [PHASE_W-1:0] r_ph  [4];
    logic [PHASE_W-1:0] r_inc [4];
    logic [ACC_W-1:0]   r_acc;

    logic [7:0]         w_addr [4];
    logic [ACC_W-1:0]   w_d;
    logic [ACC_W-1:0]   w_weighted;
    logic [PHASE_W-1:0] w_x1, w_x2, w_x3, w_x4;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_addr
            assign w_addr[gi] = r_ph[gi][PHASE_W-1 -: 8];
        end
    endgenerate

    assign w_x1 = base_inc;
    assign w_x2 = base_inc << 1;
    assign w_x3 = w_x2 + w_x1;
    assign w_x4 = base_inc << 2;

    assign w_d = {{(ACC_W-16){1'b0}}, lut_data};

    // r_k = 0..3 selects partial 1..4, whose weight is 4,3,2,1
    always_comb begin
        w_weighted = w_d;
        case (r_k)
            2'd0:    w_weighted = w_d << 2;
            2'd1:    w_weighted = (w_d << 1) + w_d;
            2'd2:    w_weighted = w_d << 1;
            default: w_weighted = w_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_k          <= 2'd0;
            r_acc        <= '0;
            lut_addr     <= 8'd0;
            sample_out   <= 16'h0000;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_ph[i]  <= '0;
                r_inc[i] <= '0;
            end
        end else begin
            sample_valid <= 1'b0;
            if (sample_req && r_state != c_ST_IDLE)
                overrun <= 1'b1;

            case (r_state)
                c_ST_IDLE: begin
                    if (sample_req) begin
                        r_acc    <= '0;
                        r_inc[0] <= w_x1;
                        r_inc[1] <= w_x2;
                        r_inc[2] <= w_x3;
                        r_inc[3] <= w_x4;
                        lut_addr <= w_addr[0];
                        r_k      <= 2'd0;
                        busy     <= 1'b1;
                        r_state  <= c_ST_ACC;
                    end
                end
                c_ST_ACC: begin
                    r_acc <= r_acc + w_weighted;
                    if (r_k != 2'd3) begin
                        lut_addr <= w_addr[r_k + 2'd1];
                        r_k      <= r_k + 2'd1;
                    end else begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    sample_out   <= r_acc[ACC_W-1 -: 16];
                    sample_valid <= 1'b1;
                    busy         <= 1'b0;
                    for (int i = 0; i < 4; i++)
                        r_ph[i] <= r_ph[i] + r_inc[i];
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_additive_osc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_additive_osc
//  Description : Self-checking bench for additive_osc against a phase/LUT model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_additive_osc;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_req;
    logic [23:0] base_inc;
    logic [7:0]  lut_addr;
    logic [15:0] lut_data;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        busy;
    logic        overrun;

    additive_osc #(.PHASE_W(24), .ACC_W(20)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_req   (sample_req),
        .base_inc     (base_inc),
        .lut_addr     (lut_addr),
        .lut_data     (lut_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // LUT modes: 0 constant 0x8000, 1 ramp addr*256, 2 full scale, 3 random table
    int          r_mode;
    logic [15:0] r_tab [256];

    always_comb begin
        lut_data = 16'h0000;
        case (r_mode)
            0:       lut_data = 16'h8000;
            1:       lut_data = {lut_addr, 8'h00};
            2:       lut_data = 16'hFFFF;
            default: lut_data = r_tab[lut_addr];
        endcase
    end

    int n_vec = 0;
    int n_err = 0;
    int n_valid = 0;

    always @(negedge clk) if (sample_valid) n_valid++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: phases of harmonics 1..4, sticky overrun, last output
    logic [23:0] m_ph [4];
    logic        m_ovr;
    logic [15:0] m_out;

    function automatic int lut_ref(input int a);
        case (r_mode)
            0:       return 32'h8000;
            1:       return a * 256;
            2:       return 32'hFFFF;
            default: return int'(r_tab[a]);
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_ph[k] = 24'd0;
        m_ovr = 1'b0;
        m_out = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One accepted request; extra[e] raises sample_req again before edge Ee
    task automatic run_req(input logic [23:0] base, input logic [5:1] extra);
        int   ea [4];
        int   sum;
        int   vstart;
        sum = 0;
        for (int k = 0; k < 4; k++) begin
            ea[k] = int'(m_ph[k] >> 16);
            sum  += (4 - k) * lut_ref(ea[k]);
        end
        chk("held_out", sample_out, m_out);
        vstart = n_valid;
        sample_req = 1'b1;
        base_inc   = base;
        @(posedge clk); #1;
        sample_req = 1'b0;
        base_inc   = 24'($urandom);
        chk("e0_busy", busy, 1);
        chk("e0_addr", lut_addr, ea[0]);
        for (int e = 1; e <= 5; e++) begin
            sample_req = extra[e];
            @(posedge clk); #1;
            sample_req = 1'b0;
            if (extra[e]) m_ovr = 1'b1;
            if (e <= 3) chk("addr", lut_addr, ea[e]);
            if (e < 5) begin
                chk("early_valid", sample_valid, 0);
                chk("busy_mid", busy, 1);
            end else begin
                chk("valid", sample_valid, 1);
                chk("sample", sample_out, (sum >> 4) & 16'hFFFF);
                chk("busy_end", busy, 0);
            end
            chk("overrun", overrun, m_ovr);
        end
        @(posedge clk); #1;
        chk("valid_pulse", sample_valid, 0);
        chk("n_valid", n_valid - vstart, 1);
        for (int k = 0; k < 4; k++) m_ph[k] = m_ph[k] + 24'((k + 1) * base);
        m_out = 16'((sum >> 4) & 16'hFFFF);
    endtask

    initial begin
        int vs;
        rst = 1'b1;
        sample_req = 1'b0;
        base_inc = 24'd0;
        r_mode = 0;
        for (int i = 0; i < 256; i++) r_tab[i] = 16'($urandom);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        chk("rst_addr", lut_addr, 0);
        chk("rst_out", sample_out, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);

        // constant table: 0x5000 every time
        r_mode = 0;
        run_req(24'd0, 5'b0);
        run_req(24'd0, 5'b0);
        chk("const_val", sample_out, 16'h5000);

        // ramp: 0 then 320
        do_reset();
        r_mode = 1;
        run_req(24'h010000, 5'b0);
        chk("ramp0", sample_out, 16'd0);
        run_req(24'h010000, 5'b0);
        chk("ramp1", sample_out, 16'd320);

        // full scale
        r_mode = 2;
        run_req(24'h123456, 5'b0);
        chk("full", sample_out, 16'h9FFF);

        // phase wrap: second request addresses FF,FE,FD,FC
        do_reset();
        r_mode = 1;
        run_req(24'hFF0000, 5'b0);
        run_req(24'hFF0000, 5'b0);

        // overrun at E2 and in the DONE cycle (sampled at E5)
        do_reset();
        r_mode = 0;
        run_req(24'h000100, 5'b10010);
        repeat (4) @(posedge clk);
        #1;
        chk("ovr_sticky", overrun, 1);
        run_req(24'h000100, 5'b0);
        do_reset();
        chk("ovr_cleared", overrun, 0);

        // reset at E3 aborts, phases restart
        r_mode = 1;
        run_req(24'h010000, 5'b0);
        vs = n_valid;
        sample_req = 1'b1;
        base_inc = 24'h010000;
        @(posedge clk); #1;
        sample_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("abort_addr", lut_addr, 0);
        chk("abort_out", sample_out, 0);
        chk("abort_valid", sample_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ovr", overrun, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_nvalid", n_valid - vs, 0);
        run_req(24'h010000, 5'b0);
        chk("restart", sample_out, 16'h0000);

        // reset and request together: request dropped
        rst = 1'b1;
        sample_req = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sample_req = 1'b0;
        model_reset();
        chk("rstreq_busy", busy, 0);
        @(posedge clk); #1;
        chk("rstreq_busy2", busy, 0);

        // randomized table, increments, gaps and occasional overruns
        r_mode = 3;
        for (int n = 0; n < 40; n++) begin
            logic [5:1] ex;
            ex = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run_req(24'($urandom), ex);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
